// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Round-robin arbiter and command sequencer for a single port of the 8x8
// dual-port RAM. N requesters share the port, with at most one read or write
// issued per clock. Read data comes back tagged with the requester index.
// After reset, or when clr is asserted, the whole array is swept to zero
// before any request is granted.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   clr             request a full zero sweep of the RAM
//   req/we          per-requester request (held until granted) and write flag
//   addr/wdata      per-requester address / write data, slice i = [i*W +: W]
//   gnt             one-hot grant, combinational in the request cycle
//   busy            high while the zero sweep is running
//   rvalid/rid      read data valid and owning requester, 2 cycles after gnt
//   rdata           read data (direct copy of ram_dout)
//   ram_en/we/ad/din  registered RAM command
//   ram_dout        RAM registered read output
module ram_port_arbiter #(
  parameter  int N  = 4,
  parameter  int AW = 3,
  parameter  int DW = 8,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] wdata,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic            rvalid,
  output logic [IW-1:0]   rid,
  output logic [DW-1:0]   rdata,
  output logic            ram_en,
  output logic            ram_we,
  output logic [AW-1:0]   ram_ad,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;        // sweep address
  logic [IW-1:0] ptr_q, ptr_d;        // last granted requester
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_ad_q, ram_ad_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  // Read tag pipe: stage 1 tracks the cycle the RAM sees the command,
  // stage 2 lines up with the RAM's registered output.
  logic          v1_q, v1_d;
  logic [IW-1:0] id1_q, id1_d;
  logic          v2_q, v2_d;
  logic [IW-1:0] id2_q, id2_d;

  // Round-robin winner search starting just after the last granted index.
  logic          found;
  logic [IW-1:0] win;
  logic          grant_ok;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(ptr_q) + k) % N]) begin
        found = 1'b1;
        win   = IW'((int'(ptr_q) + k) % N);
      end
    end
  end

  // clr blocks new grants in the same cycle so the sweep is never raced.
  assign grant_ok = (state_q == RUN) && !clr && found;

  always_comb begin
    gnt = '0;
    if (grant_ok) gnt[win] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    ram_en_d  = 1'b0;
    ram_we_d  = 1'b0;
    ram_ad_d  = ram_ad_q;
    ram_din_d = ram_din_q;
    v1_d      = 1'b0;
    id1_d     = id1_q;
    v2_d      = v1_q;
    id2_d     = id1_q;

    unique case (state_q)
      CLEAR: begin
        ram_en_d  = 1'b1;
        ram_we_d  = 1'b1;
        ram_ad_d  = cnt_q;
        ram_din_d = '0;
        // A clr during the sweep restarts it; the write at this edge still
        // happens, but the sweep cannot finish on it.
        if (clr) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == {AW{1'b1}}) state_d = RUN;
        end
      end
      RUN: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (grant_ok) begin
          ram_en_d  = 1'b1;
          ram_we_d  = we[win];
          ram_ad_d  = addr[int'(win)*AW +: AW];
          ram_din_d = wdata[int'(win)*DW +: DW];
          ptr_d     = win;
          v1_d      = !we[win];
          id1_d     = win;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      ptr_q     <= IW'(N - 1);
      ram_en_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_ad_q  <= '0;
      ram_din_q <= '0;
      v1_q      <= 1'b0;
      id1_q     <= '0;
      v2_q      <= 1'b0;
      id2_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      ram_en_q  <= ram_en_d;
      ram_we_q  <= ram_we_d;
      ram_ad_q  <= ram_ad_d;
      ram_din_q <= ram_din_d;
      v1_q      <= v1_d;
      id1_q     <= id1_d;
      v2_q      <= v2_d;
      id2_q     <= id2_d;
    end
  end

  assign busy    = (state_q == CLEAR);
  assign rvalid  = v2_q;
  assign rid     = id2_q;
  assign rdata   = ram_dout;
  assign ram_en  = ram_en_q;
  assign ram_we  = ram_we_q;
  assign ram_ad  = ram_ad_q;
  assign ram_din = ram_din_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: behavioural RAM, per-cycle reference model
// with a read scoreboard, directed scenarios with literal expectations, then
// randomized requesters with occasional clr and reset.
module tb_ram_port_arbiter;

  localparam int N     = 4;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int IW    = 2;
  localparam int WORDS = 8;

  logic            clk   = 1'b0;
  logic            rst   = 1'b0;
  logic            clr   = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N-1:0]    we    = '0;
  logic [N*AW-1:0] addr  = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    gnt;
  logic            busy, rvalid;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_ad;
  logic [DW-1:0]   ram_din;
  logic [DW-1:0]   ram_dout = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .gnt(gnt), .busy(busy), .rvalid(rvalid), .rid(rid),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM port with registered read output; starts with non-zero garbage.
  logic [DW-1:0] ram_mem [WORDS] = '{default: 8'hEE};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_ad] <= ram_din;
      else        ram_dout <= ram_mem[ram_ad];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rq[$];
  logic [DW-1:0] mmem [WORDS];
  int            cyc     = 0;
  bit            m_clear = 1'b1;
  int            m_sweep = 0;
  int            m_ptr   = N - 1;
  logic          m_en    = 1'b0;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_ad    = '0;
  logic [DW-1:0] m_din   = '0;
  int            m_win;
  logic [N-1:0]  m_gexp;
  bit            m_rv;

  // Outputs for cycle cyc are compared at its falling edge, then the model
  // advances across the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 1);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_ad", ram_ad, 0);
      check("rst_ram_din", ram_din, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rid", rid, 0);
      m_clear = 1'b1; m_sweep = 0; m_ptr = N - 1;
      m_en = 1'b0; m_we = 1'b0; m_ad = '0; m_din = '0;
      rq.delete();
    end else begin
      m_win = -1;
      if (!m_clear && !clr) begin
        for (int k = 1; k <= N; k++) begin
          if (m_win < 0 && req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        end
      end
      m_gexp = (m_win >= 0) ? (N'(1) << m_win) : '0;
      check("gnt", gnt, m_gexp);
      check("busy", busy, m_clear);
      check("ram_en", ram_en, m_en);
      check("ram_we", ram_we, m_we);
      check("ram_ad", ram_ad, m_ad);
      check("ram_din", ram_din, m_din);
      m_rv = (rq.size() > 0) && (rq[0].due == cyc);
      check("rvalid", rvalid, m_rv);
      if (m_rv) begin
        check("rid", rid, rq[0].id);
        check("rdata", rdata, rq[0].data);
        void'(rq.pop_front());
      end
      if (m_clear) begin
        m_en = 1'b1; m_we = 1'b1; m_ad = AW'(m_sweep); m_din = '0;
        mmem[m_sweep] = '0;
        if (clr)                     m_sweep = 0;
        else if (m_sweep == WORDS-1) m_clear = 1'b0;
        else                         m_sweep++;
      end else if (clr) begin
        m_clear = 1'b1; m_sweep = 0; m_en = 1'b0; m_we = 1'b0;
      end else if (m_win >= 0) begin
        m_en  = 1'b1;
        m_we  = we[m_win];
        m_ad  = addr[m_win*AW +: AW];
        m_din = wdata[m_win*DW +: DW];
        m_ptr = m_win;
        if (m_we) mmem[m_ad] = m_din;
        else      rq.push_back('{due: cyc + 2, id: m_win, data: mmem[m_ad]});
      end else begin
        m_en = 1'b0; m_we = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  // One cycle in which granted requesters drop their request.
  task automatic cycle_consume();
    logic [N-1:0] g;
    @(negedge clk); g = gnt;
    @(posedge clk); #1;
    req = req & ~g;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    // Sweep: addresses 0..7 on consecutive edges, busy falls after the 8th.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("sweep_ad", ram_ad, k);
      check("sweep_we", ram_we, 1);
      check("sweep_din", ram_din, 0);
      check("sweep_busy", busy, (k < 7) ? 1 : 0);
    end
    for (int a = 0; a < WORDS; a++) begin
      set_req(0, 1'b0, AW'(a), 8'h00);
      cycle_consume();
    end
    repeat (2) tick();

    // Write then read address 3 from requester 0.
    set_req(0, 1'b1, 3'd3, 8'hA5);
    @(negedge clk); check("t2_wr_gnt", gnt, 4'b0001);
    @(posedge clk); #1; req[0] = 1'b0;
    set_req(0, 1'b0, 3'd3, 8'h00);
    @(negedge clk); check("t2_rd_gnt", gnt, 4'b0001);
    @(posedge clk); #1; req[0] = 1'b0;
    @(posedge clk); #1;
    check("t2_rvalid", rvalid, 1);
    check("t2_rid", rid, 0);
    check("t2_rdata", rdata, 8'hA5);

    // Preload 0x10..0x13 then all four read continuously.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), DW'(8'h10 + i));
    repeat (N) cycle_consume();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 8'h00);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t3_gnt", gnt, 1 << ((1 + k) % N));
      if (k >= 2) begin
        check("t3_rvalid", rvalid, 1);
        check("t3_rid", rid, (k - 1) % N);
        check("t3_rdata", rdata, 8'h10 + (k - 1) % N);
      end
      @(posedge clk); #1;
    end
    req = '0;

    // Grant 2, then 1 and 3 together: 3 wins before 1.
    set_req(2, 1'b0, 3'd2, 8'h00);
    @(negedge clk); check("t4_gnt2", gnt, 4'b0100);
    @(posedge clk); #1; req = '0;
    set_req(1, 1'b0, 3'd1, 8'h00);
    set_req(3, 1'b0, 3'd3, 8'h00);
    @(negedge clk); check("t4_gnt3", gnt, 4'b1000);
    @(posedge clk); #1; req[3] = 1'b0;
    @(negedge clk); check("t4_gnt1", gnt, 4'b0010);
    @(posedge clk); #1; req = '0;
    repeat (2) tick();

    // Read issued, then clr next cycle: read still returns, then sweep.
    set_req(0, 1'b0, 3'd1, 8'h00);
    @(negedge clk); check("t5_gnt", gnt, 4'b0001);
    @(posedge clk); #1; req = '0; clr = 1'b1;
    set_req(2, 1'b0, 3'd2, 8'h00);
    @(negedge clk);
    check("t5_clr_gnt", gnt, 0);
    check("t5_clr_busy", busy, 0);
    @(posedge clk); #1; clr = 1'b0;
    @(negedge clk);
    check("t5_rvalid", rvalid, 1);
    check("t5_rid", rid, 0);
    check("t5_rdata", rdata, 8'h11);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check("t5_busy", busy, 1);
      check("t5_gnt_blk", gnt, 0);
      @(posedge clk); #1;
      check("t5_sweep_ad", ram_ad, k);
    end
    @(negedge clk);
    check("t5_busy_low", busy, 0);
    check("t5_gnt_after", gnt, 4'b0100);
    @(posedge clk); #1; req = '0;
    @(posedge clk); #1;
    check("t5_rd_rvalid", rvalid, 1);
    check("t5_rd_rid", rid, 2);
    check("t5_rd_zero", rdata, 8'h00);

    // Reset in the middle of back-to-back reads.
    set_req(0, 1'b0, 3'd0, 8'h00);
    set_req(1, 1'b0, 3'd1, 8'h00);
    repeat (4) tick();
    check("t6_pre_en", ram_en, 1);
    check("t6_pre_rvalid", rvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_en_drop", ram_en, 0);
    check("t6_rvalid_drop", rvalid, 0);
    check("t6_gnt_drop", gnt, 0);
    check("t6_busy", busy, 1);
    req = '0;
    tick();
    rst = 1'b0;
    tick();
    check("t6_sweep_ad0", ram_ad, 0);
    check("t6_sweep_we", ram_we, 1);
    repeat (8) tick();

    // Randomized requesters with occasional clr and reset pulses.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] g;
      @(negedge clk); g = gnt;
      @(posedge clk); #1;
      rst = 1'b0;
      req = req & ~g;
      clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, WORDS - 1)),
                  DW'($urandom_range(0, 255)));
      end
    end
    rst = 1'b0; clr = 1'b0; req = '0;
    repeat (12) tick();
    check("drain_queue", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
